conv_maxpool: RTL and testbench
===============================

// Module: conv_maxpool
// PURPOSE
//  Downstream stage of the convolution engine. Consumes the raster-order
//    feature-map stream produced by the conv layer-2 PEs.
//  Applies 2x2, stride-2 max pooling and emits the pooled map in raster order.
//  Uses a half-width line buffer of partial maxima, with valid/ready on both sides.
//  One frame per start; done pulses when the last pooled pixel is consumed.
// PARAMETERS
//  DATA_W  8  pixel width, unsigned
//  IMG_W   8  input frame width in pixels; even, >=2
//  IMG_H   8  input frame height in pixels; even, >=2
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  start      in   1          1-cycle pulse; arms a frame when IDLE
//  in_data    in   DATA_W     conv output pixel
//  in_valid   in   1          in_data valid
//  in_ready   out  1          stage accepts in_data this cycle
//  out_data   out  DATA_W     pooled pixel (registered)
//  out_valid  out  1          out_data valid
//  out_ready  in   1          consumer accepts out_data
//  busy       out  1          high in RUN
//  done       out  1          1-cycle pulse at end of frame
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, col=row=0, pair_max=0, all outputs 0.
//    Line-buffer contents are don't-care.
//  FSM IDLE->RUN on start. RUN->DONE on the output handshake of the last
//    pooled pixel. DONE->IDLE unconditionally; done=1 only in DONE.
//    A start pulse outside IDLE is ignored.
//  in_ready = (state==RUN) && !(out_valid && !out_ready).
//    A pixel is accepted when in_valid && in_ready.
//  Per accepted pixel, counters col (0..IMG_W-1) and row (0..IMG_H-1) advance:
//    col wraps to 0 and row increments at col==IMG_W-1.
//    Both reset to 0 on the last pixel of the frame.
//  Even row, even col: pair_max <= in.
//  Even row, odd col:  lbuf[col>>1] <= max(pair_max, in).
//  Odd row, even col:  pair_max <= max(lbuf[col>>1], in).
//  Odd row, odd col:   out_data <= max(pair_max, in); out_valid <= 1.
//  Latency: out_valid rises 1 cycle after acceptance of the bottom-right pixel.
//  out_valid falls on out_valid && out_ready, unless a new result loads in the
//    same cycle. A same-cycle load is possible because in_ready=1 when out_ready=1.
//  out_data and out_valid are held stable while out_valid && !out_ready.
//  Compare is unsigned. On ties either operand is acceptable (values equal).
//  Number of outputs = (IMG_W/2)*(IMG_H/2). The last one is at
//    row=IMG_H-1, col=IMG_W-1.
//  in_valid while not in RUN: in_ready=0, the pixel is not consumed.
//  The lbuf entry is written and read in different rows, so no hazard exists.
//  rst_n low mid-frame: immediate return to IDLE; a pending out_valid is dropped.
// TESTING
//  IMG_W=IMG_H=4, in=0..15 raster, out_ready=1 -> out 5,7,13,15; done 1 cycle
//    after the handshake of 15.
//  Same frame, in=15..0 -> out 15,13,7,5.
//  Backpressure: out_ready=0 for 5 cycles after the first out_valid ->
//    in_ready=0 and out_data=5 held; resume gives the same 4 outputs.
//  Random in_valid gaps (~50%) on 8x8 ramp in=r*8+c -> out (2i+1)*8+(2j+1),
//    16 values, then done.
//  Values 255 and 0 mixed in each window -> 255 emitted with no wrap/sign error.
//  rst_n pulse after 6 of 16 pixels -> IDLE, outputs 0.
//    New start + full frame -> correct 4 outputs.

Source files
------------

// File: rtl/conv_maxpool.sv
// 2x2 stride-2 max pooling over a raster pixel stream.
// Half-width line buffer of pair maxima, valid/ready on both sides.
module conv_maxpool #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LW = IMG_W / 2;
  localparam int HW = (LW > 1) ? $clog2(LW) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_pair;
  logic [DATA_W-1:0] r_out;
  logic              r_ov;
  logic              r_last;
  logic [DATA_W-1:0] r_lbuf [LW];

  logic              w_acc;
  logic              w_ohs;
  logic              w_col_end;
  logic              w_row_end;
  logic [CW-1:0]     w_half;
  logic [HW-1:0]     w_idx;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_max;

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign out_data  = r_out;
  assign out_valid = r_ov;
  assign in_ready  = busy && !(r_ov && !out_ready);
  assign w_acc     = in_valid && in_ready;
  assign w_ohs     = r_ov && out_ready;
  assign w_col_end = (r_col == COL_LAST);
  assign w_row_end = (r_row == ROW_LAST);
  assign w_half    = r_col >> 1;
  assign w_idx     = w_half[HW-1:0];

  // Odd-row even-col pixels pair with the stored top-row maximum.
  assign w_a   = (r_row[0] && !r_col[0]) ? r_lbuf[w_idx] : r_pair;
  assign w_max = (w_a > in_data) ? w_a : in_data;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_ohs && r_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_pair  <= '0;
      r_out   <= '0;
      r_ov    <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DONE) r_last <= 1'b0;
      else if (w_acc && w_col_end && w_row_end) r_last <= 1'b1;
      if (w_acc) begin
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_acc && r_row[0] && r_col[0]) begin
        r_out <= w_max;
        r_ov  <= 1'b1;
      end else if (w_ohs) begin
        r_ov  <= 1'b0;
      end
      if (w_acc && !r_col[0]) begin
        r_pair <= r_row[0] ? w_max : in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc && !r_row[0] && r_col[0]) r_lbuf[w_idx] <= w_max;
  end

endmodule

// File: tb/tb_conv_maxpool.sv
// Randomized bench for conv_maxpool: 4x4 and 8x8 instances
// checked against a window-maximum reference model.
`timescale 1ns/1ps
module tb_conv_maxpool;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start     [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic       busy      [2];
  logic       done      [2];
  logic [7:0] in_data   [2];
  logic [7:0] out_data  [2];

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] frame [$];
  logic [7:0] exp_q [2][$];
  logic [7:0] got_q [2][$];
  logic       exp_done   [2];
  logic       prev_stall [2];
  logic [7:0] prev_data  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    conv_maxpool #(
      .DATA_W(8),
      .IMG_W (g == 0 ? 4 : 8),
      .IMG_H (g == 0 ? 4 : 8)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[g]),
      .in_data  (in_data[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .out_data (out_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
  end

  task automatic check(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  // Reference: maximum of each non-overlapping 2x2 window, raster order.
  task automatic model(int d, int w, int h);
    exp_q[d].delete();
    for (int i = 0; i < h / 2; i++)
      for (int j = 0; j < w / 2; j++) begin
        int m = 0;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++) begin
            int v = frame[(2 * i + dy) * w + 2 * j + dx];
            if (v > m) m = v;
          end
        exp_q[d].push_back(8'(m));
      end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        exp_done[d]   = 1'b0;
        prev_stall[d] = 1'b0;
      end else begin
        if (exp_done[d] || done[d])
          check("done_pulse", int'(done[d]), int'(exp_done[d]));
        exp_done[d] = 1'b0;
        if (prev_stall[d]) begin
          check("hold_valid", int'(out_valid[d]), 1);
          check("hold_data", int'(out_data[d]), int'(prev_data[d]));
        end
        if (out_valid[d] && !out_ready[d])
          check("in_ready_stall", int'(in_ready[d]), 0);
        if (in_valid[d] && !busy[d])
          check("in_ready_idle", int'(in_ready[d]), 0);
        if (out_valid[d] && out_ready[d]) begin
          if (exp_q[d].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL extra_out: got %0d, want none", out_data[d]);
          end else begin
            logic [7:0] e;
            e = exp_q[d].pop_front();
            check("pooled", int'(out_data[d]), int'(e));
            got_q[d].push_back(out_data[d]);
            if (exp_q[d].size() == 0) exp_done[d] = 1'b1;
          end
        end
        prev_stall[d] = out_valid[d] && !out_ready[d];
        prev_data[d]  = out_data[d];
      end
    end
  end

  task automatic run_frame(int d, int w, int h, int gap, int rdy,
                           int stall, int limit, bit dup);
    int n = w * h;
    int idx = 0;
    int cyc = 0;
    int stall_left = 0;
    bit seen = 0;
    bit done_seen = 0;
    bit acc;
    got_q[d].delete();
    @(posedge clk); #1;
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    while (cyc < 3000) begin
      if (limit < n && idx >= limit) break;
      if (idx >= n && done_seen) break;
      start[d]    = dup && (cyc == 7);
      in_valid[d] = (idx < n) && ($urandom_range(99) >= gap);
      in_data[d]  = (idx < n) ? frame[idx] : 8'd0;
      if (out_valid[d] && !seen) begin
        seen = 1;
        stall_left = stall;
      end
      if (stall_left > 0) begin
        out_ready[d] = 1'b0;
        stall_left--;
      end else begin
        out_ready[d] = ($urandom_range(99) < rdy);
      end
      @(negedge clk);
      acc = in_valid[d] && in_ready[d];
      if (done[d]) done_seen = 1;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    if (cyc >= 3000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: dut %0d got %0d pixels, want %0d", d, idx, n);
    end
    start[d]     = 1'b0;
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
  endtask

  task automatic check_got(int d, string nm, logic [7:0] lit [$]);
    check({nm, "_count"}, got_q[d].size(), lit.size());
    for (int k = 0; k < lit.size() && k < got_q[d].size(); k++)
      check(nm, int'(got_q[d][k]), int'(lit[k]));
  endtask

  task automatic check_idle(int d, string nm);
    check({nm, "_out_valid"}, int'(out_valid[d]), 0);
    check({nm, "_out_data"}, int'(out_data[d]), 0);
    check({nm, "_busy"}, int'(busy[d]), 0);
    check({nm, "_done"}, int'(done[d]), 0);
    check({nm, "_in_ready"}, int'(in_ready[d]), 0);
  endtask

  task automatic ramp(int n);
    frame.delete();
    for (int k = 0; k < n; k++) frame.push_back(8'(k));
  endtask

  initial begin
    logic [7:0] lit [$];
    for (int d = 0; d < 2; d++) begin
      start[d] = 0;
      in_valid[d] = 0;
      in_data[d] = 0;
      out_ready[d] = 1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle(0, "rst4");
    check_idle(1, "rst8");
    rst_n = 1'b1;
    @(posedge clk); #1;

    ramp(16);
    model(0, 4, 4);
    lit = '{8'd5, 8'd7, 8'd13, 8'd15};
    for (int k = 0; k < 4; k++)
      check("model_pin_ramp", int'(exp_q[0][k]), int'(lit[k]));
    run_frame(0, 4, 4, 0, 100, 0, 16, 0);
    check_got(0, "ramp4", lit);

    frame.delete();
    for (int k = 15; k >= 0; k--) frame.push_back(8'(k));
    model(0, 4, 4);
    run_frame(0, 4, 4, 0, 100, 0, 16, 0);
    check_got(0, "desc4", '{8'd15, 8'd13, 8'd7, 8'd5});

    ramp(16);
    model(0, 4, 4);
    run_frame(0, 4, 4, 0, 100, 5, 16, 0);
    check_got(0, "stall4", '{8'd5, 8'd7, 8'd13, 8'd15});

    ramp(64);
    model(1, 8, 8);
    lit.delete();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        lit.push_back(8'((2 * i + 1) * 8 + 2 * j + 1));
    for (int k = 0; k < 16; k++)
      check("model_pin_8x8", int'(exp_q[1][k]), int'(lit[k]));
    run_frame(1, 8, 8, 50, 100, 0, 64, 1);
    check_got(1, "ramp8", lit);

    frame.delete();
    for (int k = 0; k < 16; k++) frame.push_back(8'($urandom_range(254, 1)));
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        int p = $urandom_range(3);
        int q = (p + 1 + $urandom_range(2)) % 4;
        frame[(2 * i + p / 2) * 4 + 2 * j + p % 2] = 8'd255;
        frame[(2 * i + q / 2) * 4 + 2 * j + q % 2] = 8'd0;
      end
    model(0, 4, 4);
    run_frame(0, 4, 4, 20, 70, 0, 16, 0);
    check_got(0, "extreme4", '{8'd255, 8'd255, 8'd255, 8'd255});

    for (int t = 0; t < 3; t++) begin
      frame.delete();
      for (int k = 0; k < 64; k++) frame.push_back(8'($urandom_range(255)));
      model(1, 8, 8);
      run_frame(1, 8, 8, 30, 60, 0, 64, 0);
      check("rand8_count", got_q[1].size(), 16);
    end

    ramp(16);
    model(0, 4, 4);
    run_frame(0, 4, 4, 0, 100, 0, 6, 0);
    rst_n = 1'b0;
    #1;
    check_idle(0, "midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q[0].delete();
    in_valid[0] = 1'b1;
    in_data[0]  = 8'd99;
    repeat (2) @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    model(0, 4, 4);
    run_frame(0, 4, 4, 0, 100, 0, 16, 0);
    check_got(0, "after_rst", '{8'd5, 8'd7, 8'd13, 8'd15});

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
